ysyx_22050133_axi_arbiter: RTL and testbench
============================================

# ysyx_22050133_axi_arbiter

Two-master, one-slave arbiter that shares the single AXI-like burst port between the instruction cache and the data cache. It sits between the two cache instances' `axi_*` memory-side ports and the AXI bridge. It grants one cache at a time, holds the grant for the whole burst (address phase plus all data beats), and routes handshakes so the non-granted cache sees no ready or valid.

## Interface
- `ADDR_WIDTH`, 32, request address width
- `DATA_WIDTH`, 64, data beat width
- `clk`  input  1  single clock; everything is on the rising edge
- `rst_n`  input  1  asynchronous, active-low reset
- `ic_addr_valid_i` / `dc_addr_valid_i`  input  1  requester address valid
- `ic_addr_ready_o` / `dc_addr_ready_o`  output  1  address accepted; asserted only toward the owner
- `ic_addr_i` / `dc_addr_i`  input  ADDR_WIDTH  burst start address
- `ic_we_i` / `dc_we_i`  input  1  1 = write burst
- `ic_len_i` / `dc_len_i`  input  8  beats minus 1
- `ic_size_i` / `dc_size_i`  input  3  beat size code
- `ic_burst_i` / `dc_burst_i`  input  2  burst type
- `ic_w_valid_i` / `dc_w_valid_i`  input  1  write beat valid
- `ic_w_ready_o` / `dc_w_ready_o`  output  1  write beat accepted; owner only
- `ic_w_data_i` / `dc_w_data_i`  input  DATA_WIDTH  write beat
- `ic_r_valid_o` / `dc_r_valid_o`  output  1  read beat valid; owner only
- `ic_r_ready_i` / `dc_r_ready_i`  input  1  requester read ready
- `ic_r_data_o` / `dc_r_data_o`  output  DATA_WIDTH  read beat, broadcast to both requesters
- `mem_addr_valid_o`, `mem_addr_ready_i`, `mem_addr_o`, `mem_we_o`, `mem_len_o`, `mem_size_o`, `mem_burst_o`, `mem_if_o` (1 = owner is the I-cache), `mem_w_valid_o`, `mem_w_ready_i`, `mem_w_data_o`, `mem_r_valid_i`, `mem_r_ready_o`, `mem_r_data_i`: downstream port. Widths match the requester side.

## Operation
- States:
  - `S_IDLE`
  - `S_ADDR`: address phase
  - `S_WDATA`: write beats
  - `S_RDATA`: read beats
- Registers: `owner` (0 = I, 1 = D) and an 8-bit `beats` counter.
- `S_IDLE`:
  - If any `*_addr_valid_i` is high, latch the winner into `owner` and go to `S_ADDR`.
  - Default policy is fixed priority: the D-cache wins a tie.
- `S_ADDR`:
  - All `mem_addr_*` outputs are driven combinationally from the owner's inputs.
  - `<owner>_addr_ready_o = mem_addr_ready_i`.
  - On the handshake: load `beats <= len`, then go to `S_WDATA` if `we`, else `S_RDATA`.
- `S_WDATA`:
  - The owner's `w_*` signals are routed to `mem_w_*`; `mem_w_ready_i` goes back to the owner.
  - Each accepted beat decrements `beats`.
  - A beat accepted while `beats == 0` is the last one: go to `S_IDLE`.
- `S_RDATA`:
  - `mem_r_valid_i` is routed to the owner; `mem_r_ready_o` takes the owner's `r_ready`.
  - Same counting rule as `S_WDATA`; after the last beat, go to `S_IDLE`.
- Non-owner outputs are `addr_ready = 0`, `w_ready = 0`, `r_valid = 0` in every state.
- In `S_IDLE` every `mem_*_valid_o` and `mem_r_ready_o` is 0.
- Requesters must hold `addr_valid` and the request fields stable until `addr_ready`. The arbiter does not re-arbitrate once in `S_ADDR`.
- The arbiter never reorders beats and never buffers data. It is a pure mux plus sequencer.

## Timing
- Reset values:
  - State `S_IDLE`, `owner = 0`, `beats = 0`.
  - All `*_ready_o`, `*_valid_o` and `mem_if_o` are 0.
  - Data and address outputs are 0.
- Grant latency: a request first seen in cycle N gets `mem_addr_valid_o` in cycle N+1.
- Back-to-back bursts: after the last beat the arbiter spends 1 cycle in `S_IDLE`, so the gap is 1 dead cycle.
- `len = 0`: the single beat completes the burst.
- `len = 255`: the counter must not wrap before the last beat.
- The address handshake and the first data beat never overlap, because the data states are entered only after the address handshake.
- A new request that arrives during a burst waits; it is evaluated in the next `S_IDLE` cycle.
- `rst_n` low mid-burst:
  - Immediate return to `S_IDLE` with all valids and readies at 0.
  - The downstream bridge and both caches share the same reset.

## Configuration
- `YSYX_22050133_ARB_RR_EN`:
  - Defined: round-robin arbitration. A 1-bit `last` register records the previous owner, and a tie goes to the other requester.
  - Undefined: fixed D-over-I priority and no `last` register.

## Structure
- Shared package holds:
  - State encoding `S_IDLE..S_RDATA`.
  - Owner encoding.
  - The existing `ysyx_22050133_AXI_SIZE_*` and `AXI_BURST_TYPE_*` constants.
- Optional sub-module `ysyx_22050133_arb_pick`: combinational winner select, with `last` as an input when RR is enabled.

## Test plan
- I-cache read, `len = 7`, at `0x8000_0000`, D idle:
  - `mem_if_o = 1` and 8 beats are routed to `ic_r_valid_o`.
  - `dc_r_valid_o` stays 0.
  - Back in `S_IDLE` on the cycle after beat 8.
- Both requesters valid in the same cycle, fixed priority: the D burst is served first; the I grant starts 1 cycle after D's last beat.
- Same as above with RR enabled, D served last time: I wins the tie.
- D write, `len = 0`, data `0xDEAD_BEEF_0000_0001`, `mem_w_ready_i` stalled 3 cycles:
  - Exactly one beat is transferred.
  - `mem_w_valid_o` is held during the stall.
  - `S_IDLE` follows.
- `mem_addr_ready_i` low for 5 cycles while I is granted and D asserts a request: D's `addr_ready` stays 0 throughout and the grant does not switch.
- `rst_n` pulsed low during beat 3 of a `len = 7` read: all outputs are 0 that cycle and the next request is granted normally.

Source files
------------

// File: rtl/ysyx_22050133_axi_arbiter_pkg.sv
// ysyx_22050133_axi_arbiter_pkg: shared types and AXI constants for the I/D cache arbiter
//   state_t : arbiter sequencer states
//   owner_t : which cache currently owns the memory port
package ysyx_22050133_axi_arbiter_pkg;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ADDR  = 2'd1,
        S_WDATA = 2'd2,
        S_RDATA = 2'd3
    } state_t;

    typedef enum logic {
        OWN_I = 1'b0,
        OWN_D = 1'b1
    } owner_t;

    localparam logic [2:0] ysyx_22050133_AXI_SIZE_BYTES_1   = 3'b000;
    localparam logic [2:0] ysyx_22050133_AXI_SIZE_BYTES_2   = 3'b001;
    localparam logic [2:0] ysyx_22050133_AXI_SIZE_BYTES_4   = 3'b010;
    localparam logic [2:0] ysyx_22050133_AXI_SIZE_BYTES_8   = 3'b011;
    localparam logic [2:0] ysyx_22050133_AXI_SIZE_BYTES_16  = 3'b100;
    localparam logic [2:0] ysyx_22050133_AXI_SIZE_BYTES_32  = 3'b101;
    localparam logic [2:0] ysyx_22050133_AXI_SIZE_BYTES_64  = 3'b110;
    localparam logic [2:0] ysyx_22050133_AXI_SIZE_BYTES_128 = 3'b111;

    localparam logic [1:0] AXI_BURST_TYPE_FIXED = 2'b00;
    localparam logic [1:0] AXI_BURST_TYPE_INCR  = 2'b01;
    localparam logic [1:0] AXI_BURST_TYPE_WRAP  = 2'b10;

endpackage

// File: rtl/ysyx_22050133_arb_pick.sv
// ysyx_22050133_arb_pick: combinational winner select between I-cache and D-cache requests
//   ic_req_i / dc_req_i : request lines
//   last_i              : previous owner (only with YSYX_22050133_ARB_RR_EN)
//   win_o               : selected owner
// Macro YSYX_22050133_ARB_RR_EN selects round-robin; default is fixed D-over-I priority.
module ysyx_22050133_arb_pick
    import ysyx_22050133_axi_arbiter_pkg::*;
(
    input  logic   ic_req_i,
    input  logic   dc_req_i,
`ifdef YSYX_22050133_ARB_RR_EN
    input  owner_t last_i,
`endif
    output owner_t win_o
);

`ifdef YSYX_22050133_ARB_RR_EN
    // On a tie the requester that did not own the port last time wins
    assign win_o = (ic_req_i && dc_req_i) ? ((last_i == OWN_D) ? OWN_I : OWN_D)
                                          : (dc_req_i ? OWN_D : OWN_I);
`else
    assign win_o = dc_req_i ? OWN_D : OWN_I;
`endif

endmodule

// File: rtl/ysyx_22050133_axi_arbiter.sv
// ysyx_22050133_axi_arbiter: shares one AXI-like burst port between the I-cache and D-cache
//   ic_* / dc_* : requester ports (address phase, write beats, read beats)
//   mem_*       : downstream port to the AXI bridge; mem_if_o = 1 while the I-cache owns it
// Grant is held for the address phase plus all data beats; outputs are a pure mux of the
// owner's signals, gated by state so the idle port and the non-owner see zeros.
// Macro YSYX_22050133_ARB_RR_EN enables round-robin tie breaking.
module ysyx_22050133_axi_arbiter
    import ysyx_22050133_axi_arbiter_pkg::*;
#(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 64
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  ic_addr_valid_i,
    output logic                  ic_addr_ready_o,
    input  logic [ADDR_WIDTH-1:0] ic_addr_i,
    input  logic                  ic_we_i,
    input  logic [7:0]            ic_len_i,
    input  logic [2:0]            ic_size_i,
    input  logic [1:0]            ic_burst_i,
    input  logic                  ic_w_valid_i,
    output logic                  ic_w_ready_o,
    input  logic [DATA_WIDTH-1:0] ic_w_data_i,
    output logic                  ic_r_valid_o,
    input  logic                  ic_r_ready_i,
    output logic [DATA_WIDTH-1:0] ic_r_data_o,
    input  logic                  dc_addr_valid_i,
    output logic                  dc_addr_ready_o,
    input  logic [ADDR_WIDTH-1:0] dc_addr_i,
    input  logic                  dc_we_i,
    input  logic [7:0]            dc_len_i,
    input  logic [2:0]            dc_size_i,
    input  logic [1:0]            dc_burst_i,
    input  logic                  dc_w_valid_i,
    output logic                  dc_w_ready_o,
    input  logic [DATA_WIDTH-1:0] dc_w_data_i,
    output logic                  dc_r_valid_o,
    input  logic                  dc_r_ready_i,
    output logic [DATA_WIDTH-1:0] dc_r_data_o,
    output logic                  mem_addr_valid_o,
    input  logic                  mem_addr_ready_i,
    output logic [ADDR_WIDTH-1:0] mem_addr_o,
    output logic                  mem_we_o,
    output logic [7:0]            mem_len_o,
    output logic [2:0]            mem_size_o,
    output logic [1:0]            mem_burst_o,
    output logic                  mem_if_o,
    output logic                  mem_w_valid_o,
    input  logic                  mem_w_ready_i,
    output logic [DATA_WIDTH-1:0] mem_w_data_o,
    input  logic                  mem_r_valid_i,
    output logic                  mem_r_ready_o,
    input  logic [DATA_WIDTH-1:0] mem_r_data_i
);

    state_t     state_q, state_d;
    owner_t     owner_q, owner_d;
    logic [7:0] beats_q, beats_d;
    owner_t     win;
    logic       is_d, in_addr, in_w, in_r, beat_hs;

`ifdef YSYX_22050133_ARB_RR_EN
    owner_t last_q, last_d;
`endif

    ysyx_22050133_arb_pick u_pick (
        .ic_req_i (ic_addr_valid_i),
        .dc_req_i (dc_addr_valid_i),
`ifdef YSYX_22050133_ARB_RR_EN
        .last_i   (last_q),
`endif
        .win_o    (win)
    );

    assign is_d    = (owner_q == OWN_D);
    assign in_addr = (state_q == S_ADDR);
    assign in_w    = (state_q == S_WDATA);
    assign in_r    = (state_q == S_RDATA);

    assign mem_addr_valid_o = in_addr && (is_d ? dc_addr_valid_i : ic_addr_valid_i);
    assign mem_addr_o       = in_addr ? (is_d ? dc_addr_i  : ic_addr_i)  : '0;
    assign mem_we_o         = in_addr && (is_d ? dc_we_i : ic_we_i);
    assign mem_len_o        = in_addr ? (is_d ? dc_len_i   : ic_len_i)   : '0;
    assign mem_size_o       = in_addr ? (is_d ? dc_size_i  : ic_size_i)  : '0;
    assign mem_burst_o      = in_addr ? (is_d ? dc_burst_i : ic_burst_i) : '0;
    // owner_q resets to the I-cache encoding, so qualify with state to keep mem_if_o low when idle
    assign mem_if_o         = (state_q != S_IDLE) && !is_d;
    assign mem_w_valid_o    = in_w && (is_d ? dc_w_valid_i : ic_w_valid_i);
    assign mem_w_data_o     = in_w ? (is_d ? dc_w_data_i : ic_w_data_i) : '0;
    assign mem_r_ready_o    = in_r && (is_d ? dc_r_ready_i : ic_r_ready_i);

    assign ic_addr_ready_o = in_addr && !is_d && mem_addr_ready_i;
    assign dc_addr_ready_o = in_addr &&  is_d && mem_addr_ready_i;
    assign ic_w_ready_o    = in_w && !is_d && mem_w_ready_i;
    assign dc_w_ready_o    = in_w &&  is_d && mem_w_ready_i;
    assign ic_r_valid_o    = in_r && !is_d && mem_r_valid_i;
    assign dc_r_valid_o    = in_r &&  is_d && mem_r_valid_i;
    assign ic_r_data_o     = in_r ? mem_r_data_i : '0;
    assign dc_r_data_o     = in_r ? mem_r_data_i : '0;

    assign beat_hs = (in_w && mem_w_valid_o && mem_w_ready_i) ||
                     (in_r && mem_r_valid_i && mem_r_ready_o);

    always_comb begin
        state_d = state_q;
        owner_d = owner_q;
        beats_d = beats_q;
`ifdef YSYX_22050133_ARB_RR_EN
        last_d  = last_q;
`endif
        case (state_q)
            S_IDLE: begin
                if (ic_addr_valid_i || dc_addr_valid_i) begin
                    state_d = S_ADDR;
                    owner_d = win;
`ifdef YSYX_22050133_ARB_RR_EN
                    last_d  = win;
`endif
                end
            end
            S_ADDR: begin
                if (mem_addr_valid_o && mem_addr_ready_i) begin
                    beats_d = mem_len_o;
                    state_d = mem_we_o ? S_WDATA : S_RDATA;
                end
            end
            default: begin
                // beats_q counts remaining beats minus one; a beat taken at zero ends the burst
                if (beat_hs) begin
                    if (beats_q == 8'd0) state_d = S_IDLE;
                    else                 beats_d = beats_q - 8'd1;
                end
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            owner_q <= OWN_I;
            beats_q <= 8'd0;
`ifdef YSYX_22050133_ARB_RR_EN
            last_q  <= OWN_I;
`endif
        end else begin
            state_q <= state_d;
            owner_q <= owner_d;
            beats_q <= beats_d;
`ifdef YSYX_22050133_ARB_RR_EN
            last_q  <= last_d;
`endif
        end
    end

endmodule

// File: tb/tb_ysyx_22050133_axi_arbiter.sv
// tb_ysyx_22050133_axi_arbiter: directed bench for the I/D cache AXI arbiter
module tb_ysyx_22050133_axi_arbiter;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        ic_addr_valid_i, ic_addr_ready_o, ic_we_i, ic_w_valid_i, ic_w_ready_o;
    logic        ic_r_valid_o, ic_r_ready_i;
    logic [31:0] ic_addr_i;
    logic [7:0]  ic_len_i;
    logic [2:0]  ic_size_i;
    logic [1:0]  ic_burst_i;
    logic [63:0] ic_w_data_i, ic_r_data_o;
    logic        dc_addr_valid_i, dc_addr_ready_o, dc_we_i, dc_w_valid_i, dc_w_ready_o;
    logic        dc_r_valid_o, dc_r_ready_i;
    logic [31:0] dc_addr_i;
    logic [7:0]  dc_len_i;
    logic [2:0]  dc_size_i;
    logic [1:0]  dc_burst_i;
    logic [63:0] dc_w_data_i, dc_r_data_o;
    logic        mem_addr_valid_o, mem_addr_ready_i, mem_we_o, mem_if_o;
    logic [31:0] mem_addr_o;
    logic [7:0]  mem_len_o;
    logic [2:0]  mem_size_o;
    logic [1:0]  mem_burst_o;
    logic        mem_w_valid_o, mem_w_ready_i, mem_r_valid_i, mem_r_ready_o;
    logic [63:0] mem_w_data_o, mem_r_data_i;

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    ysyx_22050133_axi_arbiter dut (
        .clk(clk), .rst_n(rst_n),
        .ic_addr_valid_i(ic_addr_valid_i), .ic_addr_ready_o(ic_addr_ready_o), .ic_addr_i(ic_addr_i),
        .ic_we_i(ic_we_i), .ic_len_i(ic_len_i), .ic_size_i(ic_size_i), .ic_burst_i(ic_burst_i),
        .ic_w_valid_i(ic_w_valid_i), .ic_w_ready_o(ic_w_ready_o), .ic_w_data_i(ic_w_data_i),
        .ic_r_valid_o(ic_r_valid_o), .ic_r_ready_i(ic_r_ready_i), .ic_r_data_o(ic_r_data_o),
        .dc_addr_valid_i(dc_addr_valid_i), .dc_addr_ready_o(dc_addr_ready_o), .dc_addr_i(dc_addr_i),
        .dc_we_i(dc_we_i), .dc_len_i(dc_len_i), .dc_size_i(dc_size_i), .dc_burst_i(dc_burst_i),
        .dc_w_valid_i(dc_w_valid_i), .dc_w_ready_o(dc_w_ready_o), .dc_w_data_i(dc_w_data_i),
        .dc_r_valid_o(dc_r_valid_o), .dc_r_ready_i(dc_r_ready_i), .dc_r_data_o(dc_r_data_o),
        .mem_addr_valid_o(mem_addr_valid_o), .mem_addr_ready_i(mem_addr_ready_i),
        .mem_addr_o(mem_addr_o), .mem_we_o(mem_we_o), .mem_len_o(mem_len_o),
        .mem_size_o(mem_size_o), .mem_burst_o(mem_burst_o), .mem_if_o(mem_if_o),
        .mem_w_valid_o(mem_w_valid_o), .mem_w_ready_i(mem_w_ready_i), .mem_w_data_o(mem_w_data_o),
        .mem_r_valid_i(mem_r_valid_i), .mem_r_ready_o(mem_r_ready_o), .mem_r_data_i(mem_r_data_i)
    );

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic req(input bit d, input logic we, input logic [7:0] len, input logic [31:0] addr);
        if (d) begin
            dc_addr_valid_i = 1'b1; dc_we_i = we; dc_len_i = len; dc_addr_i = addr;
            dc_size_i = 3'd3; dc_burst_i = 2'd1;
        end else begin
            ic_addr_valid_i = 1'b1; ic_we_i = we; ic_len_i = len; ic_addr_i = addr;
            ic_size_i = 3'd3; ic_burst_i = 2'd1;
        end
    endtask

    // Called at the negedge of the cycle the arbiter should be in S_ADDR for requester d
    task automatic serve(input bit d, input logic we, input logic [7:0] len, input logic [31:0] addr,
                         input logic [63:0] base, input int astall, input int dstall);
        logic [63:0] data;
        for (int s = 0; s < astall; s++) begin
            mem_addr_ready_i = 1'b0;
            #1;
            chk("astall_if", 64'(mem_if_o), 64'(!d));
            chk("astall_ic_rdy", 64'(ic_addr_ready_o), 64'd0);
            chk("astall_dc_rdy", 64'(dc_addr_ready_o), 64'd0);
            @(negedge clk);
        end
        mem_addr_ready_i = 1'b1;
        #1;
        chk("addr_valid", 64'(mem_addr_valid_o), 64'd1);
        chk("mem_if", 64'(mem_if_o), 64'(!d));
        chk("mem_addr", 64'(mem_addr_o), 64'(addr));
        chk("mem_len", 64'(mem_len_o), 64'(len));
        chk("mem_we", 64'(mem_we_o), 64'(we));
        chk("mem_size", 64'(mem_size_o), 64'd3);
        chk("mem_burst", 64'(mem_burst_o), 64'd1);
        chk("own_addr_rdy", 64'(d ? dc_addr_ready_o : ic_addr_ready_o), 64'd1);
        chk("oth_addr_rdy", 64'(d ? ic_addr_ready_o : dc_addr_ready_o), 64'd0);
        @(negedge clk);
        mem_addr_ready_i = 1'b0;
        if (d) dc_addr_valid_i = 1'b0; else ic_addr_valid_i = 1'b0;
        for (int b = 0; b <= int'(len); b++) begin
            data = base + 64'(b);
            if (we) begin
                if (d) begin dc_w_valid_i = 1'b1; dc_w_data_i = data; end
                else   begin ic_w_valid_i = 1'b1; ic_w_data_i = data; end
                mem_w_ready_i = 1'b0;
            end else begin
                if (d) dc_r_ready_i = 1'b1; else ic_r_ready_i = 1'b1;
                mem_r_valid_i = 1'b0;
                mem_r_data_i  = data;
            end
            for (int s = 0; s < ((b == 0) ? dstall : 0); s++) begin
                #1;
                if (we) begin
                    chk("stall_w_valid", 64'(mem_w_valid_o), 64'd1);
                    chk("stall_w_rdy", 64'(d ? dc_w_ready_o : ic_w_ready_o), 64'd0);
                end else begin
                    chk("stall_r_rdy", 64'(mem_r_ready_o), 64'd1);
                    chk("stall_r_valid", 64'(d ? dc_r_valid_o : ic_r_valid_o), 64'd0);
                end
                @(negedge clk);
            end
            if (we) mem_w_ready_i = 1'b1; else mem_r_valid_i = 1'b1;
            #1;
            chk("no_addr_in_data", 64'(mem_addr_valid_o), 64'd0);
            if (we) begin
                chk("w_valid", 64'(mem_w_valid_o), 64'd1);
                chk("w_data", mem_w_data_o, data);
                chk("own_w_rdy", 64'(d ? dc_w_ready_o : ic_w_ready_o), 64'd1);
                chk("oth_w_rdy", 64'(d ? ic_w_ready_o : dc_w_ready_o), 64'd0);
            end else begin
                chk("r_ready", 64'(mem_r_ready_o), 64'd1);
                chk("r_data", d ? dc_r_data_o : ic_r_data_o, data);
                chk("own_r_valid", 64'(d ? dc_r_valid_o : ic_r_valid_o), 64'd1);
                chk("oth_r_valid", 64'(d ? ic_r_valid_o : dc_r_valid_o), 64'd0);
            end
            @(negedge clk);
        end
        // Data inputs still active here: the idle arbiter must gate them all off
        #1;
        chk("idle_if", 64'(mem_if_o), 64'd0);
        chk("idle_w_valid", 64'(mem_w_valid_o), 64'd0);
        chk("idle_r_ready", 64'(mem_r_ready_o), 64'd0);
        chk("idle_ic_r_valid", 64'(ic_r_valid_o), 64'd0);
        chk("idle_dc_r_valid", 64'(dc_r_valid_o), 64'd0);
        chk("idle_w_rdy", 64'({ic_w_ready_o, dc_w_ready_o}), 64'd0);
        chk("idle_addr_valid", 64'(mem_addr_valid_o), 64'd0);
        ic_w_valid_i = 1'b0; dc_w_valid_i = 1'b0; mem_w_ready_i = 1'b0;
        mem_r_valid_i = 1'b0; ic_r_ready_i = 1'b0; dc_r_ready_i = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        bit first;
        rst_n = 1'b0;
        ic_addr_valid_i = 0; ic_addr_i = 0; ic_we_i = 0; ic_len_i = 0; ic_size_i = 0; ic_burst_i = 0;
        ic_w_valid_i = 0; ic_w_data_i = 0; ic_r_ready_i = 0;
        dc_addr_valid_i = 0; dc_addr_i = 0; dc_we_i = 0; dc_len_i = 0; dc_size_i = 0; dc_burst_i = 0;
        dc_w_valid_i = 0; dc_w_data_i = 0; dc_r_ready_i = 0;
        mem_addr_ready_i = 1; mem_w_ready_i = 1; mem_r_valid_i = 1; mem_r_data_i = 64'h55;
        repeat (2) @(negedge clk);
        #1;
        chk("rst_addr_valid", 64'(mem_addr_valid_o), 64'd0);
        chk("rst_if", 64'(mem_if_o), 64'd0);
        chk("rst_readies", 64'({ic_addr_ready_o, dc_addr_ready_o, ic_w_ready_o, dc_w_ready_o}), 64'd0);
        chk("rst_valids", 64'({ic_r_valid_o, dc_r_valid_o, mem_w_valid_o, mem_r_ready_o}), 64'd0);
        chk("rst_data", ic_r_data_o | dc_r_data_o | mem_w_data_o | 64'(mem_addr_o), 64'd0);
        mem_addr_ready_i = 0; mem_w_ready_i = 0; mem_r_valid_i = 0; mem_r_data_i = 0;
        @(negedge clk);
        rst_n = 1'b1;

        // I-cache read, 8 beats
        req(1'b0, 1'b0, 8'd7, 32'h8000_0000);
        #1 chk("latency_idle", 64'(mem_addr_valid_o), 64'd0);
        @(negedge clk);
        serve(1'b0, 1'b0, 8'd7, 32'h8000_0000, 64'h1000, 0, 0);

        // D write, single beat, w_ready stalled 3 cycles
        req(1'b1, 1'b1, 8'd0, 32'h8000_0100);
        @(negedge clk);
        serve(1'b1, 1'b1, 8'd0, 32'h8000_0100, 64'hDEAD_BEEF_0000_0001, 0, 3);

        // Simultaneous requests; D owned the port last time
        req(1'b0, 1'b0, 8'd3, 32'h8000_1000);
        req(1'b1, 1'b0, 8'd1, 32'h8000_2000);
        #1 chk("tie_latency_idle", 64'(mem_addr_valid_o), 64'd0);
        @(negedge clk);
`ifdef YSYX_22050133_ARB_RR_EN
        first = 1'b0;
`else
        first = 1'b1;
`endif
        if (first) serve(1'b1, 1'b0, 8'd1, 32'h8000_2000, 64'h200, 0, 1);
        else       serve(1'b0, 1'b0, 8'd3, 32'h8000_1000, 64'h100, 0, 1);
        @(negedge clk);
        if (first) serve(1'b0, 1'b0, 8'd3, 32'h8000_1000, 64'h100, 0, 0);
        else       serve(1'b1, 1'b0, 8'd1, 32'h8000_2000, 64'h200, 0, 0);

        // I granted, address stalled 5 cycles while D requests
        req(1'b0, 1'b0, 8'd2, 32'h8000_3000);
        @(negedge clk);
        req(1'b1, 1'b1, 8'd1, 32'h8000_5000);
        serve(1'b0, 1'b0, 8'd2, 32'h8000_3000, 64'h300, 5, 0);
        @(negedge clk);
        serve(1'b1, 1'b1, 8'd1, 32'h8000_5000, 64'h500, 0, 0);

        // Maximum burst length
        req(1'b0, 1'b0, 8'd255, 32'h8000_6000);
        @(negedge clk);
        serve(1'b0, 1'b0, 8'd255, 32'h8000_6000, 64'h6000, 0, 0);

        // Reset during beat 3 of an 8-beat read
        req(1'b0, 1'b0, 8'd7, 32'h8000_4000);
        @(negedge clk);
        mem_addr_ready_i = 1'b1;
        @(negedge clk);
        mem_addr_ready_i = 1'b0; ic_addr_valid_i = 1'b0;
        mem_r_valid_i = 1'b1; ic_r_ready_i = 1'b1; mem_r_data_i = 64'hABCD;
        repeat (3) @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("mid_rst_r_valid", 64'({ic_r_valid_o, dc_r_valid_o}), 64'd0);
        chk("mid_rst_r_ready", 64'(mem_r_ready_o), 64'd0);
        chk("mid_rst_if", 64'(mem_if_o), 64'd0);
        chk("mid_rst_r_data", ic_r_data_o, 64'd0);
        @(negedge clk);
        rst_n = 1'b1; mem_r_valid_i = 1'b0; ic_r_ready_i = 1'b0; mem_r_data_i = 64'd0;
        req(1'b0, 1'b0, 8'd0, 32'h8000_7000);
        #1 chk("post_rst_idle", 64'(mem_addr_valid_o), 64'd0);
        @(negedge clk);
        serve(1'b0, 1'b0, 8'd0, 32'h8000_7000, 64'h7000, 0, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
